// File: rtl/paddle_move_ctrl.sv
// paddle_move_ctrl
//   Turns one player's raw up/down push-buttons into debounced, rate-limited,
//   single-cycle step strobes for the paddle position stage. No strobe is ever
//   produced on a bounce, and up/down strobes are never produced together.
//
// Ports
//   pixelClock  in   clock, all logic on its rising edge
//   Reset       in   synchronous, active-high
//   btnUp       in   raw asynchronous up button
//   btnDown     in   raw asynchronous down button
//   upPaddle    out  one-cycle up-step strobe
//   downPaddle  out  one-cycle down-step strobe
//   upHeld      out  debounced, active-high up level
//   downHeld    out  debounced, active-high down level
//
// Build option
//   PADDLE_ACCEL_EN  when defined, after ACCEL_HOLD_STEPS strobes in one
//                    continuous hold the strobe period drops to
//                    ACCEL_STEP_CYCLES. Undefined: period is always STEP_CYCLES.
module paddle_move_ctrl #(
  parameter int DEBOUNCE_CYCLES   = 400000,
  parameter int STEP_CYCLES       = 100000,
  parameter int ACCEL_STEP_CYCLES = 40000,
  parameter int ACCEL_HOLD_STEPS  = 32,
  parameter bit BTN_ACTIVE_LOW    = 1'b1
) (
  input  logic pixelClock,
  input  logic Reset,
  input  logic btnUp,
  input  logic btnDown,
  output logic upPaddle,
  output logic downPaddle,
  output logic upHeld,
  output logic downHeld
);

  localparam int DB_W       = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int PERIOD_MAX = (STEP_CYCLES > ACCEL_STEP_CYCLES) ? STEP_CYCLES : ACCEL_STEP_CYCLES;
  localparam int STEP_W     = (PERIOD_MAX > 1) ? $clog2(PERIOD_MAX) : 1;

  localparam logic [DB_W-1:0]   DB_LAST      = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [STEP_W-1:0] STEP_RELOAD  = STEP_W'(STEP_CYCLES - 1);
  localparam logic [STEP_W-1:0] ACCEL_RELOAD = STEP_W'(ACCEL_STEP_CYCLES - 1);

`ifdef PADDLE_ACCEL_EN
  localparam bit ACCEL_BUILT = 1'b1;
  localparam int HOLD_W      = (ACCEL_HOLD_STEPS > 0) ? $clog2(ACCEL_HOLD_STEPS + 1) : 1;
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(ACCEL_HOLD_STEPS);
`else
  localparam bit ACCEL_BUILT = 1'b0;
`endif
  // The entry strobe is the first of the hold, so a threshold of one or less
  // means the very first reload is already the fast one.
  localparam bit ACCEL_ON_ENTRY = ACCEL_BUILT && (ACCEL_HOLD_STEPS <= 1);
  localparam logic [STEP_W-1:0] ENTRY_RELOAD = ACCEL_ON_ENTRY ? ACCEL_RELOAD : STEP_RELOAD;

  // Bit 0 = up, bit 1 = down.
  localparam logic [1:0] IDLE_RAW = {2{BTN_ACTIVE_LOW}};

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_MOVE_UP   = 2'd1,
    ST_MOVE_DOWN = 2'd2
  } state_t;

  logic [1:0]        r_sync_p0;
  logic [1:0]        r_sync_p1;
  logic [1:0]        w_synced;

  logic [DB_W-1:0]   r_up_db_cnt;
  logic [DB_W-1:0]   r_dn_db_cnt;
  logic              r_up_held;
  logic              r_dn_held;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [STEP_W-1:0] r_step_cnt;
  logic [STEP_W-1:0] w_step_nxt;
  logic              r_up_paddle;
  logic              r_dn_paddle;
  logic              w_up_nxt;
  logic              w_dn_nxt;
  logic              w_dir_up;
  logic              w_dir_dn;
  logic              w_keep;
  logic              w_accel;

`ifdef PADDLE_ACCEL_EN
  logic [HOLD_W-1:0] r_hold_cnt;
  logic [HOLD_W-1:0] w_hold_nxt;
  logic [HOLD_W-1:0] w_hold_inc;
`endif

  // ---- stage p0/p1: two-flop synchronizer, parked at the released level in reset
  always_ff @(posedge pixelClock) begin
    if (Reset) begin
      r_sync_p0 <= IDLE_RAW;
      r_sync_p1 <= IDLE_RAW;
    end else begin
      r_sync_p0 <= {btnDown, btnUp};
      r_sync_p1 <= r_sync_p0;
    end
  end

  assign w_synced = r_sync_p1 ^ IDLE_RAW;

  // ---- debounce: accept a new level only after DEBOUNCE_CYCLES differing samples in a row
  always_ff @(posedge pixelClock) begin
    if (Reset) begin
      r_up_db_cnt <= '0;
      r_up_held   <= 1'b0;
    end else if (w_synced[0] == r_up_held) begin
      r_up_db_cnt <= '0;
    end else if (r_up_db_cnt == DB_LAST) begin
      r_up_held   <= w_synced[0];
      r_up_db_cnt <= '0;
    end else begin
      r_up_db_cnt <= r_up_db_cnt + DB_W'(1);
    end
  end

  always_ff @(posedge pixelClock) begin
    if (Reset) begin
      r_dn_db_cnt <= '0;
      r_dn_held   <= 1'b0;
    end else if (w_synced[1] == r_dn_held) begin
      r_dn_db_cnt <= '0;
    end else if (r_dn_db_cnt == DB_LAST) begin
      r_dn_held   <= w_synced[1];
      r_dn_db_cnt <= '0;
    end else begin
      r_dn_db_cnt <= r_dn_db_cnt + DB_W'(1);
    end
  end

  // ---- direction resolve and step FSM; both held resolves to no direction
  assign w_dir_up = r_up_held & ~r_dn_held;
  assign w_dir_dn = r_dn_held & ~r_up_held;
  assign w_keep   = ((r_state == ST_MOVE_UP)   && w_dir_up) ||
                    ((r_state == ST_MOVE_DOWN) && w_dir_dn);

`ifdef PADDLE_ACCEL_EN
  assign w_hold_inc = (r_hold_cnt == HOLD_MAX) ? r_hold_cnt : r_hold_cnt + HOLD_W'(1);
  // w_hold_inc counts step strobes after the entry strobe, so +1 is the
  // number of strobes issued in this hold including the one going out now.
  assign w_accel    = ((int'(w_hold_inc) + 1) >= ACCEL_HOLD_STEPS);
`else
  assign w_accel    = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_step_nxt  = r_step_cnt;
    w_up_nxt    = 1'b0;
    w_dn_nxt    = 1'b0;
`ifdef PADDLE_ACCEL_EN
    w_hold_nxt  = r_hold_cnt;
`endif
    case (r_state)
      ST_IDLE: begin
        w_step_nxt = '0;
`ifdef PADDLE_ACCEL_EN
        w_hold_nxt = '0;
`endif
        if (w_dir_up) begin
          w_state_nxt = ST_MOVE_UP;
          w_up_nxt    = 1'b1;
          w_step_nxt  = ENTRY_RELOAD;
        end else if (w_dir_dn) begin
          w_state_nxt = ST_MOVE_DOWN;
          w_dn_nxt    = 1'b1;
          w_step_nxt  = ENTRY_RELOAD;
        end
      end
      default: begin
        if (w_keep) begin
          if (r_step_cnt == '0) begin
            w_up_nxt   = (r_state == ST_MOVE_UP);
            w_dn_nxt   = (r_state == ST_MOVE_DOWN);
            w_step_nxt = w_accel ? ACCEL_RELOAD : STEP_RELOAD;
`ifdef PADDLE_ACCEL_EN
            w_hold_nxt = w_hold_inc;
`endif
          end else begin
            w_step_nxt = r_step_cnt - STEP_W'(1);
          end
        end else begin
          // Leaving a move never strobes, even if the period expired this cycle.
          w_state_nxt = ST_IDLE;
          w_step_nxt  = '0;
`ifdef PADDLE_ACCEL_EN
          w_hold_nxt  = '0;
`endif
        end
      end
    endcase
  end

  always_ff @(posedge pixelClock) begin
    if (Reset) begin
      r_state     <= ST_IDLE;
      r_step_cnt  <= '0;
      r_up_paddle <= 1'b0;
      r_dn_paddle <= 1'b0;
`ifdef PADDLE_ACCEL_EN
      r_hold_cnt  <= '0;
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_step_cnt  <= w_step_nxt;
      r_up_paddle <= w_up_nxt;
      r_dn_paddle <= w_dn_nxt;
`ifdef PADDLE_ACCEL_EN
      r_hold_cnt  <= w_hold_nxt;
`endif
    end
  end

  assign upPaddle   = r_up_paddle;
  assign downPaddle = r_dn_paddle;
  assign upHeld     = r_up_held;
  assign downHeld   = r_dn_held;

endmodule

// File: tb/tb_paddle_move_ctrl.sv
`timescale 1ns/1ps
module tb_paddle_move_ctrl;

  localparam int DEB   = 4;
  localparam int STEP  = 8;
  localparam int ASTEP = 2;
  localparam int AHOLD = 3;
  localparam int MAXC  = 8192;

  logic clk    = 1'b0;
  logic rst    = 1'b1;
  logic btn_up = 1'b1;
  logic btn_dn = 1'b1;
  logic up_p, dn_p, up_h, dn_h;

  paddle_move_ctrl #(
    .DEBOUNCE_CYCLES  (DEB),
    .STEP_CYCLES      (STEP),
    .ACCEL_STEP_CYCLES(ASTEP),
    .ACCEL_HOLD_STEPS (AHOLD),
    .BTN_ACTIVE_LOW   (1'b1)
  ) dut (
    .pixelClock(clk),
    .Reset     (rst),
    .btnUp     (btn_up),
    .btnDown   (btn_dn),
    .upPaddle  (up_p),
    .downPaddle(dn_p),
    .upHeld    (up_h),
    .downHeld  (dn_h)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, $signed(act), $signed(exp), $time);
    end
  endtask

  // ---------------- reference model (history based) ----------------
  bit raw_u [MAXC];
  bit raw_d [MAXC];
  bit rst_h [MAXC];
  int cyc = 0;
  bit m_uh, m_dh, m_up, m_dn;
  int m_dir;   // 0 none, 1 up, 2 down
  int m_due;   // edges until the next strobe
  int m_n;     // strobes issued in the current hold

  // Active-high level the debouncer observes at edge j: the raw value two
  // edges back, unless a reset edge forced the synchronizer since then.
  function automatic bit synced(input bit is_dn, input int j);
    if (j < 2) return 1'b0;
    if (rst_h[j-1] || rst_h[j-2]) return 1'b0;
    return is_dn ? ~raw_d[j-2] : ~raw_u[j-2];
  endfunction

  // Held level flips at edge t when the last DEB non-reset samples all differ.
  function automatic bit settled(input bit is_dn, input int t, input bit held);
    for (int j = t - DEB + 1; j <= t; j++) begin
      if (j < 0) return 1'b0;
      if (rst_h[j]) return 1'b0;
      if (synced(is_dn, j) == held) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic int gap(input int n);
`ifdef PADDLE_ACCEL_EN
    if (n >= AHOLD) return ASTEP;
`endif
    return STEP;
  endfunction

  task automatic model_edge();
    int want;
    bit ouh, odh;
    cyc++;
    if (cyc >= MAXC - 1) begin
      $display("FAIL model_depth: got %0d expected below %0d", cyc, MAXC - 1);
      $fatal(1, "history exhausted");
    end
    raw_u[cyc] = btn_up;
    raw_d[cyc] = btn_dn;
    rst_h[cyc] = rst;
    ouh  = m_uh;
    odh  = m_dh;
    m_up = 1'b0;
    m_dn = 1'b0;
    if (rst) begin
      m_uh = 1'b0; m_dh = 1'b0; m_dir = 0; m_due = 0; m_n = 0;
      return;
    end
    if (settled(1'b0, cyc, ouh)) m_uh = ~ouh;
    if (settled(1'b1, cyc, odh)) m_dh = ~odh;
    want = (ouh && !odh) ? 1 : ((odh && !ouh) ? 2 : 0);
    if (m_dir == 0) begin
      if (want != 0) begin
        m_dir = want; m_n = 1; m_due = gap(1);
        m_up = (want == 1); m_dn = (want == 2);
      end
    end else if (want == m_dir) begin
      m_due--;
      if (m_due == 0) begin
        m_up = (want == 1); m_dn = (want == 2);
        m_n++;
        m_due = gap(m_n);
      end
    end else begin
      m_dir = 0;
    end
  endtask

  // ---------------- per-phase observation ----------------
  int ph_i, f_uh1, f_uh0, f_up, f_dn, n_up, n_dn;
  int dn_pos[$];

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    ph_i++;
    chk("upHeld",     up_h, m_uh);
    chk("downHeld",   dn_h, m_dh);
    chk("upPaddle",   up_p, m_up);
    chk("downPaddle", dn_p, m_dn);
    chk("exclusive",  up_p & dn_p, 0);
    if (f_uh1 < 0 && up_h === 1'b1) f_uh1 = ph_i;
    if (f_uh0 < 0 && up_h === 1'b0) f_uh0 = ph_i;
    if (f_up  < 0 && up_p === 1'b1) f_up  = ph_i;
    if (f_dn  < 0 && dn_p === 1'b1) f_dn  = ph_i;
    if (up_p === 1'b1) n_up++;
    if (dn_p === 1'b1) begin n_dn++; dn_pos.push_back(ph_i); end
  endtask

  task automatic phase(input bit u, input bit d, input bit r, input int n);
    btn_up = u; btn_dn = d; rst = r;
    ph_i = 0; f_uh1 = -1; f_uh0 = -1; f_up = -1; f_dn = -1; n_up = 0; n_dn = 0;
    dn_pos.delete();
    repeat (n) tick();
  endtask

  initial begin
    int seg_len, mode;
    bit gu, gd;

    // Reset with buttons released, then idle.
    phase(1, 1, 1, 3);
    phase(1, 1, 0, 20);
    chk("idle_up_strobes", n_up, 0);
    chk("idle_dn_strobes", n_dn, 0);

    // Up press: held at +6, strobes at +7, +15, +23 (+25, +27, +29 with accel).
    phase(0, 1, 0, 30);
    chk("up_held_latency", f_uh1, 6);
    chk("up_first_strobe", f_up, 7);
`ifdef PADDLE_ACCEL_EN
    chk("up_strobe_count", n_up, 6);
`else
    chk("up_strobe_count", n_up, 3);
`endif
    chk("up_no_down", n_dn, 0);
    phase(1, 1, 0, 12);
    chk("up_release_fall", f_uh0, 6);

    // Three-cycle glitch must not be accepted.
    phase(0, 1, 0, 3);
    chk("glitch_held", f_uh1, -1);
    phase(1, 1, 0, 12);
    chk("glitch_held_after", f_uh1, -1);
    chk("glitch_strobes", n_up, 0);

    // Up held, then down joins: strobes stop; releasing up starts down.
    phase(0, 1, 0, 20);
    phase(0, 0, 0, 15);
    phase(0, 0, 0, 8);
    chk("both_up_strobes", n_up, 0);
    chk("both_dn_strobes", n_dn, 0);
    chk("both_held", up_h & dn_h, 1);
    phase(1, 0, 0, 40);
    chk("dn_after_up_fall", f_dn - f_uh0, 1);
    chk("dn_enough_strobes", dn_pos.size() >= 4, 1);
    if (dn_pos.size() >= 4) begin
      chk("dn_gap1", dn_pos[1] - dn_pos[0], STEP);
      chk("dn_gap2", dn_pos[2] - dn_pos[1], STEP);
`ifdef PADDLE_ACCEL_EN
      chk("dn_gap3", dn_pos[3] - dn_pos[2], ASTEP);
`else
      chk("dn_gap3", dn_pos[3] - dn_pos[2], STEP);
`endif
    end

    // Reset while up is strobing: immediate stop, full re-debounce after.
    phase(1, 1, 0, 10);
    phase(0, 1, 0, 20);
    phase(0, 1, 1, 1);
    chk("rst_stop_strobe", n_up, 0);
    chk("rst_clear_held", up_h, 0);
    phase(0, 1, 0, 15);
    chk("rst_reheld", f_uh1, 6);
    chk("rst_first_strobe", f_up, 7);

    // Randomized segments.
    for (int s = 0; s < 70; s++) begin
      mode = $urandom_range(0, 9);
      case (mode)
        0, 1, 2: phase(0, 1, 0, $urandom_range(10, 45));
        3, 4:    phase(1, 0, 0, $urandom_range(10, 45));
        5:       phase(0, 0, 0, $urandom_range(5, 20));
        6: begin
          gu = btn_up; gd = btn_dn;
          if ($urandom_range(0, 1) == 0) phase(~gu, gd, 0, $urandom_range(1, 3));
          else                           phase(gu, ~gd, 0, $urandom_range(1, 3));
          phase(gu, gd, 0, $urandom_range(1, 6));
        end
        7:       phase(1, 1, 0, $urandom_range(3, 12));
        8:       phase(btn_up, btn_dn, 1, $urandom_range(1, 2));
        default: begin
          seg_len = $urandom_range(5, 15);
          for (int c = 0; c < seg_len; c++)
            phase(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0, 1);
        end
      endcase
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
